// File: rtl/axi4lite_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi4lite_arbiter
//  Purpose  : N-master to 1-slave AXI4-Lite arbiter. The read and write
//             channels are arbitrated independently, each with round-robin
//             fairness and one outstanding transaction.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             m_aw*/m_w*/m_b*     - packed per-master write channels
//                                   (master i at slice [i*W +: W])
//             m_ar*/m_r*          - packed per-master read channels
//             s_*                 - single master-side port to interconnect
//             wr_grant, rd_grant  - one-hot current owners, 0 when idle
//  Revision : 1.0 - initial release
// ============================================================================
module axi4lite_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    // master-facing write channels
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_awaddr,
    input  logic [NUM_MASTERS*3-1:0]            m_awprot,
    input  logic [NUM_MASTERS-1:0]              m_awvalid,
    output logic [NUM_MASTERS-1:0]              m_awready,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wstrb,
    input  logic [NUM_MASTERS-1:0]              m_wvalid,
    output logic [NUM_MASTERS-1:0]              m_wready,
    output logic [NUM_MASTERS*2-1:0]            m_bresp,
    output logic [NUM_MASTERS-1:0]              m_bvalid,
    input  logic [NUM_MASTERS-1:0]              m_bready,
    // master-facing read channels
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_araddr,
    input  logic [NUM_MASTERS*3-1:0]            m_arprot,
    input  logic [NUM_MASTERS-1:0]              m_arvalid,
    output logic [NUM_MASTERS-1:0]              m_arready,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_rdata,
    output logic [NUM_MASTERS*2-1:0]            m_rresp,
    output logic [NUM_MASTERS-1:0]              m_rvalid,
    input  logic [NUM_MASTERS-1:0]              m_rready,
    // interconnect-facing port
    output logic [ADDR_WIDTH-1:0]               s_awaddr,
    output logic [2:0]                          s_awprot,
    output logic                                s_awvalid,
    input  logic                                s_awready,
    output logic [DATA_WIDTH-1:0]               s_wdata,
    output logic [DATA_WIDTH/8-1:0]             s_wstrb,
    output logic                                s_wvalid,
    input  logic                                s_wready,
    input  logic [1:0]                          s_bresp,
    input  logic                                s_bvalid,
    output logic                                s_bready,
    output logic [ADDR_WIDTH-1:0]               s_araddr,
    output logic [2:0]                          s_arprot,
    output logic                                s_arvalid,
    input  logic                                s_arready,
    input  logic [DATA_WIDTH-1:0]               s_rdata,
    input  logic [1:0]                          s_rresp,
    input  logic                                s_rvalid,
    output logic                                s_rready,
    // ownership
    output logic [NUM_MASTERS-1:0]              wr_grant,
    output logic [NUM_MASTERS-1:0]              rd_grant
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_PTR_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [c_PTR_W-1:0]     c_LAST_IDX = c_PTR_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] c_ONE      = NUM_MASTERS'(1);

    localparam logic [1:0] c_WIDLE = 2'd0;
    localparam logic [1:0] c_WADDR = 2'd1;
    localparam logic [1:0] c_WRESP = 2'd2;

    localparam logic [1:0] c_RIDLE = 2'd0;
    localparam logic [1:0] c_RADDR = 2'd1;
    localparam logic [1:0] c_RDATA = 2'd2;

    // First requester at or after ptr in cyclic order: scan the upper part
    // [ptr, N-1] first, then wrap around to [0, ptr-1].
    function automatic logic [c_PTR_W-1:0] f_pick(
        input logic [NUM_MASTERS-1:0] req,
        input logic [c_PTR_W-1:0]     ptr
    );
        logic               found;
        logic [c_PTR_W-1:0] sel;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i] && (c_PTR_W'(i) >= ptr)) begin
                sel   = c_PTR_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i]) begin
                sel   = c_PTR_W'(i);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] idx);
        return (idx == c_LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    logic [1:0]             r_wr_state, w_wr_state_nxt;
    logic [c_PTR_W-1:0]     r_wr_idx,   w_wr_idx_nxt;
    logic [c_PTR_W-1:0]     r_wr_ptr,   w_wr_ptr_nxt;
    logic [NUM_MASTERS-1:0] r_wr_grant, w_wr_grant_nxt;
    logic                   r_aw_done,  w_aw_done_nxt;
    logic                   r_w_done,   w_w_done_nxt;
    logic [c_PTR_W-1:0]     w_wr_pick;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    logic [1:0]             r_rd_state, w_rd_state_nxt;
    logic [c_PTR_W-1:0]     r_rd_idx,   w_rd_idx_nxt;
    logic [c_PTR_W-1:0]     r_rd_ptr,   w_rd_ptr_nxt;
    logic [NUM_MASTERS-1:0] r_rd_grant, w_rd_grant_nxt;
    logic [c_PTR_W-1:0]     w_rd_pick;

    assign w_wr_pick = f_pick(m_awvalid, r_wr_ptr);
    assign w_rd_pick = f_pick(m_arvalid, r_rd_ptr);

    assign wr_grant = r_wr_grant;
    assign rd_grant = r_rd_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= c_WIDLE;
            r_wr_idx   <= '0;
            r_wr_ptr   <= '0;
            r_wr_grant <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_rd_state <= c_RIDLE;
            r_rd_idx   <= '0;
            r_rd_ptr   <= '0;
            r_rd_grant <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_idx   <= w_wr_idx_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_wr_grant <= w_wr_grant_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
            r_rd_state <= w_rd_state_nxt;
            r_rd_idx   <= w_rd_idx_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_rd_grant <= w_rd_grant_nxt;
        end
    end

    // Write FSM: grant is registered in WIDLE so there is never a
    // combinational path from m_awvalid to the grant. AW and W each carry a
    // done flag so they may complete in either order without re-issuing.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_idx_nxt   = r_wr_idx;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_wr_grant_nxt = r_wr_grant;
        w_aw_done_nxt  = r_aw_done;
        w_w_done_nxt   = r_w_done;
        s_awvalid      = 1'b0;
        s_wvalid       = 1'b0;
        s_bready       = 1'b0;
        m_awready      = '0;
        m_wready       = '0;
        m_bvalid       = '0;
        case (r_wr_state)
            c_WIDLE: begin
                if (|m_awvalid) begin
                    w_wr_idx_nxt   = w_wr_pick;
                    w_wr_grant_nxt = c_ONE << w_wr_pick;
                    w_wr_state_nxt = c_WADDR;
                end
            end
            c_WADDR: begin
                s_awvalid     = (|(m_awvalid & r_wr_grant)) & ~r_aw_done;
                s_wvalid      = (|(m_wvalid & r_wr_grant)) & ~r_w_done;
                m_awready     = r_wr_grant & {NUM_MASTERS{s_awready & ~r_aw_done}};
                m_wready      = r_wr_grant & {NUM_MASTERS{s_wready & ~r_w_done}};
                w_aw_done_nxt = r_aw_done | (s_awvalid & s_awready);
                w_w_done_nxt  = r_w_done | (s_wvalid & s_wready);
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_wr_state_nxt = c_WRESP;
                end
            end
            c_WRESP: begin
                s_bready = |(m_bready & r_wr_grant);
                m_bvalid = r_wr_grant & {NUM_MASTERS{s_bvalid}};
                if (s_bvalid && s_bready) begin
                    w_wr_state_nxt = c_WIDLE;
                    w_wr_ptr_nxt   = f_next(r_wr_idx);
                    w_wr_grant_nxt = '0;
                    w_aw_done_nxt  = 1'b0;
                    w_w_done_nxt   = 1'b0;
                end
            end
            default: begin
                w_wr_state_nxt = c_WIDLE;
                w_wr_grant_nxt = '0;
                w_aw_done_nxt  = 1'b0;
                w_w_done_nxt   = 1'b0;
            end
        endcase
    end

    // Read FSM: the single AR beat is tracked by the state itself.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_idx_nxt   = r_rd_idx;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_rd_grant_nxt = r_rd_grant;
        s_arvalid      = 1'b0;
        s_rready       = 1'b0;
        m_arready      = '0;
        m_rvalid       = '0;
        case (r_rd_state)
            c_RIDLE: begin
                if (|m_arvalid) begin
                    w_rd_idx_nxt   = w_rd_pick;
                    w_rd_grant_nxt = c_ONE << w_rd_pick;
                    w_rd_state_nxt = c_RADDR;
                end
            end
            c_RADDR: begin
                s_arvalid = |(m_arvalid & r_rd_grant);
                m_arready = r_rd_grant & {NUM_MASTERS{s_arready}};
                if (s_arvalid && s_arready) begin
                    w_rd_state_nxt = c_RDATA;
                end
            end
            c_RDATA: begin
                s_rready = |(m_rready & r_rd_grant);
                m_rvalid = r_rd_grant & {NUM_MASTERS{s_rvalid}};
                if (s_rvalid && s_rready) begin
                    w_rd_state_nxt = c_RIDLE;
                    w_rd_ptr_nxt   = f_next(r_rd_idx);
                    w_rd_grant_nxt = '0;
                end
            end
            default: begin
                w_rd_state_nxt = c_RIDLE;
                w_rd_grant_nxt = '0;
            end
        endcase
    end

    // Payload steering. Grants are one-hot, so at most one slice is picked;
    // everything not owned stays 0. Responses reach a master only while its
    // channel is in the response phase.
    always_comb begin
        s_awaddr = '0;
        s_awprot = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        s_araddr = '0;
        s_arprot = '0;
        m_bresp  = '0;
        m_rresp  = '0;
        m_rdata  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_wr_grant[i]) begin
                s_awaddr = m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_awprot = m_awprot[i*3 +: 3];
                s_wdata  = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                s_wstrb  = m_wstrb[i*c_STRB_W +: c_STRB_W];
                if (r_wr_state == c_WRESP) begin
                    m_bresp[i*2 +: 2] = s_bresp;
                end
            end
            if (r_rd_grant[i]) begin
                s_araddr = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_arprot = m_arprot[i*3 +: 3];
                if (r_rd_state == c_RDATA) begin
                    m_rresp[i*2 +: 2]                    = s_rresp;
                    m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4lite_arbiter
//  Purpose  : Self-checking bench for axi4lite_arbiter (2 masters, 32-bit).
//             Small master/slave models run in lockstep with a tick task;
//             directed vectors plus hand-written multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4lite_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*32-1:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [N*3-1:0]  m_awprot, m_arprot;
    logic [N*4-1:0]  m_wstrb;
    logic [N*2-1:0]  m_bresp, m_rresp;
    logic [N-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0]     s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]      s_awprot, s_arprot;
    logic [3:0]      s_wstrb;
    logic [1:0]      s_bresp, s_rresp;
    logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic            s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N-1:0]    wr_grant, rd_grant;

    axi4lite_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .wr_grant(wr_grant), .rd_grant(rd_grant)
    );

    always #5 clk = ~clk;

    // ---------------- master models ----------------
    bit          wr_busy [N];
    bit          aw_sent [N];
    bit          w_sent  [N];
    int          aw_dly  [N];
    logic [31:0] wr_addr [N];
    logic [31:0] wr_data [N];
    logic [3:0]  wr_strb [N];
    bit          bready_en [N];
    logic [1:0]  got_bresp [N];
    bit          rd_busy [N];
    bit          ar_sent [N];
    logic [31:0] rd_addr [N];
    logic [31:0] got_rdata [N];
    logic [1:0]  got_rresp [N];
    int          wr_order[$];
    int          rd_order[$];

    // ---------------- slave model ----------------
    int          aw_stall;
    bit          slv_wready_lvl = 1'b1;
    bit          aw_got, w_got, b_pend, r_pend;
    logic [1:0]  slv_resp = 2'b00;
    logic [31:0] slv_rdata = 32'h0;
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    // ---------------- observation flags ----------------
    bit          iso_err;
    int          both_active;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        bit          rd;
        int          mst;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [1:0]  exp_grant;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            m_awvalid[i]         = wr_busy[i] && !aw_sent[i] && (aw_dly[i] == 0);
            m_wvalid[i]          = wr_busy[i] && !w_sent[i];
            m_awaddr[i*32 +: 32] = wr_addr[i];
            m_awprot[i*3 +: 3]   = 3'(i);
            m_wdata[i*32 +: 32]  = wr_data[i];
            m_wstrb[i*4 +: 4]    = wr_strb[i];
            m_bready[i]          = bready_en[i];
            m_arvalid[i]         = rd_busy[i] && !ar_sent[i];
            m_araddr[i*32 +: 32] = rd_addr[i];
            m_arprot[i*3 +: 3]   = 3'(i + 4);
            m_rready[i]          = 1'b1;
        end
        s_awready = (aw_stall == 0);
        s_wready  = slv_wready_lvl;
        s_bvalid  = b_pend;
        s_bresp   = b_pend ? slv_resp : 2'b00;
        s_arready = 1'b1;
        s_rvalid  = r_pend;
        s_rdata   = r_pend ? slv_rdata : 32'h0;
        s_rresp   = r_pend ? slv_resp : 2'b00;
    endtask

    // Records the handshakes that will complete on the coming rising edge.
    task automatic observe();
        bit set_r;
        set_r = 1'b0;
        if (s_awvalid && s_awready) begin
            aw_hs++; cap_awaddr = s_awaddr; aw_got = 1'b1;
        end else if (s_awvalid && aw_stall > 0) begin
            aw_stall--;
        end
        if (s_wvalid && s_wready) begin
            w_hs++; cap_wdata = s_wdata; cap_wstrb = s_wstrb; w_got = 1'b1;
        end
        if (s_bvalid && s_bready) begin
            b_hs++; b_pend = 1'b0;
        end
        if (aw_got && w_got && !b_pend) begin
            b_pend = 1'b1; aw_got = 1'b0; w_got = 1'b0;
        end
        if (s_arvalid && s_arready) begin
            ar_hs++; cap_araddr = s_araddr; set_r = 1'b1;
        end
        if (s_rvalid && s_rready) begin
            r_hs++; r_pend = 1'b0;
        end
        if (set_r) r_pend = 1'b1;
        if (wr_grant != 0 && rd_grant != 0) both_active++;
        if ($countones(wr_grant) > 1 || $countones(rd_grant) > 1) iso_err = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (!wr_grant[i] && (m_awready[i] || m_wready[i] || m_bvalid[i] || m_bresp[i*2 +: 2] != 0))
                iso_err = 1'b1;
            if (!rd_grant[i] && (m_arready[i] || m_rvalid[i] || m_rresp[i*2 +: 2] != 0 || m_rdata[i*32 +: 32] != 0))
                iso_err = 1'b1;
            if (m_awvalid[i] && m_awready[i]) aw_sent[i] = 1'b1;
            if (m_wvalid[i] && m_wready[i]) w_sent[i] = 1'b1;
            if (m_bvalid[i] && m_bready[i]) begin
                got_bresp[i] = m_bresp[i*2 +: 2];
                wr_busy[i] = 1'b0; aw_sent[i] = 1'b0; w_sent[i] = 1'b0;
                wr_order.push_back(i);
            end
            if (wr_busy[i] && aw_dly[i] > 0) aw_dly[i]--;
            if (m_arvalid[i] && m_arready[i]) ar_sent[i] = 1'b1;
            if (m_rvalid[i] && m_rready[i]) begin
                got_rdata[i] = m_rdata[i*32 +: 32];
                got_rresp[i] = m_rresp[i*2 +: 2];
                rd_busy[i] = 1'b0; ar_sent[i] = 1'b0;
                rd_order.push_back(i);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        #1;
        observe();
    endtask

    task automatic clr_model();
        for (int i = 0; i < N; i++) begin
            wr_busy[i] = 1'b0; aw_sent[i] = 1'b0; w_sent[i] = 1'b0; aw_dly[i] = 0;
            rd_busy[i] = 1'b0; ar_sent[i] = 1'b0; bready_en[i] = 1'b1;
        end
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
        aw_stall = 0; slv_wready_lvl = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_model();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_write(int i, logic [31:0] a, logic [31:0] d, logic [3:0] s, int dly);
        wr_busy[i] = 1'b1; aw_sent[i] = 1'b0; w_sent[i] = 1'b0;
        wr_addr[i] = a; wr_data[i] = d; wr_strb[i] = s; aw_dly[i] = dly;
    endtask

    task automatic start_read(int i, logic [31:0] a);
        rd_busy[i] = 1'b1; ar_sent[i] = 1'b0; rd_addr[i] = a;
    endtask

    task automatic wait_wr(int i);
        int k = 0;
        while (wr_busy[i] && k < 60) begin tick(); k++; end
        chk("wr_timeout", 64'(wr_busy[i]), 0);
    endtask

    task automatic wait_rd(int i);
        int k = 0;
        while (rd_busy[i] && k < 60) begin tick(); k++; end
        chk("rd_timeout", 64'(rd_busy[i]), 0);
    endtask

    int aw0, w0, b0, ordsz;
    int iss [N];
    bit bp_ok;

    initial begin
        vecs[0] = '{1'b0, 1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 2'b10};
        vecs[1] = '{1'b0, 0, 32'h0000_0004, 32'h0000_A5A5, 4'h3, 2'b10, 2'b01};
        vecs[2] = '{1'b1, 1, 32'h2000_0004, 32'h1234_5678, 4'h0, 2'b00, 2'b10};
        vecs[3] = '{1'b1, 0, 32'h3000_0000, 32'hCAFE_F00D, 4'h0, 2'b11, 2'b01};

        // ---- reset state ----
        do_reset();
        rst = 1'b1;
        tick();
        chk("rst_grants", {wr_grant, rd_grant}, 0);
        chk("rst_svalid", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 0);
        chk("rst_mside", {m_awready, m_wready, m_arready, m_bvalid, m_rvalid}, 0);
        chk("rst_payload", {s_awaddr, s_wdata}, 0);
        rst = 1'b0;

        // ---- single transactions from the vector table ----
        for (int v = 0; v < 4; v++) begin
            iso_err   = 1'b0;
            slv_resp  = vecs[v].resp;
            slv_rdata = vecs[v].data;
            if (!vecs[v].rd) begin
                start_write(vecs[v].mst, vecs[v].addr, vecs[v].data, vecs[v].strb, 0);
                tick();
                chk("v_wlat0", {wr_grant, s_awvalid}, 0);
                tick();
                chk("v_wgrant", wr_grant, vecs[v].exp_grant);
                chk("v_awvalid", s_awvalid, 1);
                wait_wr(vecs[v].mst);
                chk("v_awaddr", cap_awaddr, vecs[v].addr);
                chk("v_wdata", cap_wdata, vecs[v].data);
                chk("v_wstrb", cap_wstrb, vecs[v].strb);
                chk("v_bresp", got_bresp[vecs[v].mst], vecs[v].resp);
                chk("v_border", wr_order[wr_order.size()-1], vecs[v].mst);
                tick();
                chk("v_wgrant_clr", wr_grant, 0);
            end else begin
                start_read(vecs[v].mst, vecs[v].addr);
                tick();
                chk("v_rlat0", {rd_grant, s_arvalid}, 0);
                tick();
                chk("v_rgrant", rd_grant, vecs[v].exp_grant);
                chk("v_arvalid", s_arvalid, 1);
                wait_rd(vecs[v].mst);
                chk("v_araddr", cap_araddr, vecs[v].addr);
                chk("v_rdata", got_rdata[vecs[v].mst], vecs[v].data);
                chk("v_rresp", got_rresp[vecs[v].mst], vecs[v].resp);
                chk("v_rorder", rd_order[rd_order.size()-1], vecs[v].mst);
                tick();
                chk("v_rgrant_clr", rd_grant, 0);
            end
            chk("v_isolation", 64'(iso_err), 0);
        end
        slv_resp = 2'b00;

        // ---- round-robin: both masters, two writes each, right after reset ----
        do_reset();
        ordsz = wr_order.size();
        start_write(0, 32'h0000_1000, 32'h0000_0A00, 4'hF, 0);
        start_write(1, 32'h0000_2000, 32'h0000_0B00, 4'hF, 0);
        iss[0] = 1; iss[1] = 1;
        for (int k = 0; k < 200 && wr_order.size() < ordsz + 4; k++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!wr_busy[i] && iss[i] < 2) begin
                    start_write(i, 32'h0000_3000 + 32'(i), 32'h0000_0C00 + 32'(i), 4'hF, 0);
                    iss[i]++;
                end
            end
        end
        chk("rr_count", wr_order.size() - ordsz, 4);
        if (wr_order.size() >= ordsz + 4) begin
            chk("rr_order0", wr_order[ordsz],   0);
            chk("rr_order1", wr_order[ordsz+1], 1);
            chk("rr_order2", wr_order[ordsz+2], 0);
            chk("rr_order3", wr_order[ordsz+3], 1);
        end

        // ---- W three cycles ahead of AW, AW ready stalled five cycles ----
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        aw_stall = 5;
        start_write(0, 32'h4000_0008, 32'h0BAD_CAFE, 4'hC, 3);
        tick();
        chk("wfirst_noforward", {s_wvalid, m_wready[0]}, 0);
        wait_wr(0);
        chk("wfirst_aw_hs", aw_hs - aw0, 1);
        chk("wfirst_w_hs", w_hs - w0, 1);
        chk("wfirst_b_hs", b_hs - b0, 1);
        chk("wfirst_addr", cap_awaddr, 32'h4000_0008);
        chk("wfirst_data", {cap_wdata, cap_wstrb}, {32'h0BAD_CAFE, 4'hC});

        // ---- concurrent write (master 0) and read (master 1) ----
        iso_err = 1'b0; both_active = 0;
        slv_rdata = 32'h1234_5678;
        start_write(0, 32'h0000_0040, 32'h5555_AAAA, 4'hF, 0);
        start_read(1, 32'h2000_0004);
        wait_wr(0);
        wait_rd(1);
        chk("conc_both_active", 64'(both_active != 0), 1);
        chk("conc_rdata", got_rdata[1], 32'h1234_5678);
        chk("conc_araddr", cap_araddr, 32'h2000_0004);
        chk("conc_wdata", cap_wdata, 32'h5555_AAAA);
        chk("conc_isolation", 64'(iso_err), 0);

        // ---- B backpressure holds the grant and blocks master 1 ----
        aw0 = aw_hs;
        bready_en[0] = 1'b0;
        start_write(0, 32'h0000_0100, 32'h1111_1111, 4'hF, 0);
        tick();
        tick();
        start_write(1, 32'h0000_0200, 32'h2222_2222, 4'hF, 0);
        bp_ok = 1'b1;
        repeat (4) begin
            tick();
            if (s_bready !== 1'b0 || s_bvalid !== 1'b1 || wr_grant !== 2'b01 || s_awvalid !== 1'b0)
                bp_ok = 1'b0;
        end
        chk("bp_hold", 64'(bp_ok), 1);
        chk("bp_aw_blocked", aw_hs - aw0, 1);
        ordsz = wr_order.size();
        bready_en[0] = 1'b1;
        wait_wr(0);
        wait_wr(1);
        chk("bp_aw_total", aw_hs - aw0, 2);
        if (wr_order.size() >= ordsz + 2) begin
            chk("bp_order", {wr_order[ordsz], wr_order[ordsz+1]}, {32'd0, 32'd1});
        end else begin
            chk("bp_completions", wr_order.size() - ordsz, 2);
        end

        // ---- reset in WADDR after AW accepted, before W ----
        start_write(0, 32'h0000_0300, 32'h3333_3333, 4'hF, 0);
        wait_wr(0);
        tick();
        b0 = b_hs;
        slv_wready_lvl = 1'b0;
        start_write(1, 32'h0000_0400, 32'h4444_4444, 4'hF, 0);
        tick();
        tick();
        tick();
        chk("mid_pre", {s_wvalid, s_awvalid, wr_grant}, {1'b1, 1'b0, 2'b10});
        rst = 1'b1;
        tick();
        tick();
        chk("mid_rst_valids", {s_awvalid, s_wvalid, s_bready, s_arvalid}, 0);
        chk("mid_rst_grants", {wr_grant, rd_grant}, 0);
        chk("mid_rst_mready", {m_awready, m_wready}, 0);
        rst = 1'b0;
        clr_model();
        ordsz = wr_order.size();
        start_write(0, 32'h0000_0500, 32'h5555_0000, 4'hF, 0);
        start_write(1, 32'h0000_0600, 32'h6666_0000, 4'hF, 0);
        wait_wr(0);
        wait_wr(1);
        if (wr_order.size() >= ordsz + 2) begin
            chk("post_rst_order", {wr_order[ordsz], wr_order[ordsz+1]}, {32'd0, 32'd1});
        end else begin
            chk("post_rst_completions", wr_order.size() - ordsz, 2);
        end
        chk("post_rst_b_count", b_hs - b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
